mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_responder_mem_array.sv | 48 ++++
 rtl/mem_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared constants for the memory responder and the processor side that talks
// to it: FSM state encodings, default line width, default latency and the
// width of the latency down-counter.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_LINE_W  = 128;
    localparam int DEF_DEPTH   = 4096;
    localparam int DEF_LATENCY = 5;

    // Latency is limited to 1..15, so a 4-bit down-counter covers LATENCY-1.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port line storage: synchronous write, registered read.
// Contents are never cleared; only the read register is reset.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset of the read register
//   en     : perform an access this cycle
//   we     : 1 = write wdata to idx, 0 = read idx into rdata
//   clr    : load zero into rdata instead of array data (writes, errors)
//   idx    : line index
//   wdata  : write line
//   rdata  : registered read line
// -----------------------------------------------------------------------------
module mem_array #(
    parameter int LINE_W = 128,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    // No reset on the storage itself: contents survive a reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= clr ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-outstanding line memory responder. A request accepted in IDLE waits
// LATENCY cycles in BUSY (down-counter), performs the array access on the
// BUSY->RESP edge and holds the response in RESP until the processor takes it.
//
// Optional feature: define MEM_ADDR_CHECK_EN to flag line indices >= DEPTH
// with rsp_err (no write, zero read data). Without it rsp_err is tied 0 and
// the index is truncated to log2(DEPTH) bits.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : request present
//   req_ready  : request can be accepted (IDLE only, never during reset)
//   req_wr     : 1 = line write, 0 = line read
//   req_addr   : byte address, line index = upper bits above line offset
//   req_wdata  : write line
//   rsp_valid  : response present
//   rsp_ready  : processor accepts response
//   rsp_rdata  : read line (zero for writes and errors)
//   rsp_err    : line index out of range
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// BUSY  | request latched, counter running down to the array access
// RESP  | response held on rsp_* until rsp_valid && rsp_ready
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int OFF_W      = $clog2(LINE_W / 8);
    localparam int IDX_FULL_W = ADDR_W - OFF_W;
    localparam int IDX_W      = $clog2(DEPTH);

    state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_q;
    logic [IDX_FULL_W-1:0] idx_full_q;
    logic [LINE_W-1:0]     wdata_q;

    logic accept;
    logic access_now;
    logic access_err;
    logic arr_we;
    logic arr_clr;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready  = (state_q == ST_IDLE) && !rst;
        rsp_valid  = (state_q == ST_RESP);
        // Gated by rst so a reset landing on the access edge drops the write.
        access_now = (state_q == ST_BUSY) && (cnt_q == '0) && !rst;
    end

    assign accept = req_valid && req_ready;

    // -------------------------------------------------------------------------
    // Request latch and latency counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            idx_full_q <= '0;
            wdata_q    <= '0;
        end else if (accept) begin
            cnt_q      <= CNT_W'(LATENCY - 1);
            wr_q       <= req_wr;
            idx_full_q <= req_addr[ADDR_W-1:OFF_W];
            wdata_q    <= req_wdata;
        end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic err_q;
    logic rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                err_q <= (req_addr[ADDR_W-1:OFF_W] >= IDX_FULL_W'(DEPTH));
            end
            if (access_now) begin
                rsp_err_q <= err_q;
            end
        end
    end

    assign access_err = err_q;
    assign rsp_err    = rsp_err_q;
`else
    assign access_err = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    // Out-of-range requests never write; writes and errors return zero data.
    assign arr_we  = wr_q && !access_err;
    assign arr_clr = wr_q || access_err;

    // Upper index bits only matter for the range check; offset bits never do.
    logic unused_ok;
    assign unused_ok = ^{req_addr[OFF_W-1:0], idx_full_q};

    mem_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk    (clk),
        .rst    (rst),
        .en     (access_now),
        .we     (arr_we),
        .clr    (arr_clr),
        .idx    (idx_full_q[IDX_W-1:0]),
        .wdata  (wdata_q),
        .rdata  (rsp_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int DEPTH  = 4096;
    localparam int LAT    = 5;
    localparam int OFF    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [LINE_W-1:0] rsp_rdata;
    logic              rsp_err;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [LINE_W-1:0] rdata;
        logic              err;
        bit                chk_data;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    longint      cyc      = 0;
    bit          busy_m   = 0;
    bit          in_resp  = 0;
    longint      acc_cyc  = 0;
    int          rr_mode  = 0;   // 0: rsp_ready=1, 1: random, 2: rsp_ready=0
    logic [LINE_W-1:0] hold_rdata;
    logic        hold_err;
    exp_t        q[$];
    logic [LINE_W-1:0] model [longint];

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s bound expired (cycle %0d)", name, cyc);
    endtask

    // Expected response from the address/line rules, applied at accept time.
    function automatic exp_t predict(input bit wr, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
        exp_t   e;
        longint full;
        longint idx;
        bit     err;
        full = longint'(addr) >> OFF;
`ifdef MEM_ADDR_CHECK_EN
        err = (full >= DEPTH);
        idx = full;
`else
        err = 1'b0;
        idx = full % DEPTH;
`endif
        e.err = err;
        e.rdata = '0;
        e.chk_data = 1'b1;
        if (wr) begin
            if (!err) model[idx] = data;
        end else if (!err) begin
            if (model.exists(idx)) e.rdata = model[idx];
            else e.chk_data = 1'b0;
        end
        return e;
    endfunction

    task automatic issue(input bit wr, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                         input bit track, input bit drop);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        if (track) q.push_back(predict(wr, addr, data));
        @(posedge clk);
        #1;
        if (drop) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy_m && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("response_timeout");
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
            else rsp_ready = (rr_mode == 0);
        end
    end

    // Monitor: handshake rules, timing and scoreboard comparison.
    initial begin
        exp_t e;
        bit   exp_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("req_ready_in_reset", req_ready, 0);
                busy_m  = 0;
                in_resp = 0;
            end else begin
                chk("req_ready", req_ready, !busy_m);
                exp_v = busy_m && (cyc >= acc_cyc + LAT);
                chk("rsp_valid", rsp_valid, exp_v);
                if (rsp_valid && exp_v) begin
                    if (!in_resp) begin
                        if (q.size() == 0) begin
                            chk("scoreboard_entries", q.size(), 1);
                        end else begin
                            e = q.pop_front();
                            if (e.chk_data) chk("rsp_rdata", rsp_rdata, e.rdata);
                            chk("rsp_err", rsp_err, e.err);
                        end
                        hold_rdata = rsp_rdata;
                        hold_err   = rsp_err;
                        in_resp    = 1;
                    end else begin
                        chk("rsp_rdata_stable", rsp_rdata, hold_rdata);
                        chk("rsp_err_stable", rsp_err, hold_err);
                    end
                    if (rsp_ready) begin
                        busy_m  = 0;
                        in_resp = 0;
                    end
                end
                if (req_valid && req_ready) begin
                    busy_m  = 1;
                    acc_cyc = cyc + 1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [LINE_W-1:0] line_a;
        logic [LINE_W-1:0] line_b;
        logic [ADDR_W-1:0] addr;
        int line;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write then read back the same line.
        issue(1'b1, 32'h40, 128'h0123456789abcdef0123456789abcdef, 1'b1, 1'b1);
        wait_done();
        issue(1'b0, 32'h40, '0, 1'b1, 1'b1);
        wait_done();

        // Response held while rsp_ready stays low, then released.
        rr_mode = 2;
        issue(1'b0, 32'h48, '0, 1'b1, 1'b1);
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        if (!rsp_valid) fail_now("stall_valid_wait");
        repeat (3) @(negedge clk);
        rr_mode = 0;
        wait_done();

        // Reset during BUSY abandons the pending write.
        line_a = rand_line();
        line_b = ~line_a;
        issue(1'b1, 32'h80, line_a, 1'b1, 1'b1);
        wait_done();
        issue(1'b1, 32'h80, line_b, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        issue(1'b0, 32'h80, '0, 1'b1, 1'b1);
        wait_done();

        // Index DEPTH: error with the range check, alias of line 0 without.
        issue(1'b1, 32'h0, rand_line(), 1'b1, 1'b1);
        wait_done();
        issue(1'b0, 32'h10000, '0, 1'b1, 1'b1);
        wait_done();

        // Random back-to-back traffic, req_valid held through BUSY/RESP.
        rr_mode = 1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) line = 4096 + int'($urandom_range(0, 3));
            else line = int'($urandom_range(0, 15));
            addr = (ADDR_W'(line) << OFF) | ADDR_W'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), addr, rand_line(), 1'b1, 1'b0);
        end
        req_valid = 1'b0;
        wait_done();
        rr_mode = 0;
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
